// File: rtl/updown_mod_counter.sv
// WIDTH-bit loadable up/down counter with programmable modulus, wrap/saturate,
// prescaled count enable, registered terminal-count pulse and sticky wrap flag.
module updown_mod_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  count_en,
    input  logic                  dir,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_flag,
    input  logic                  oe,
    output logic [WIDTH-1:0]      count_out,
    output logic                  tc_pulse,
    output logic                  wrap_flag
);

    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  tc_q, tc_d;
    logic                  flag_q, flag_d;
    logic                  tick;
    logic                  boundary;

    always_comb begin
        tick     = count_en && !load && (pre_q == prescale);
        boundary = tick && (dir ? (count_q >= modulus) : (count_q == '0));

        pre_d = pre_q;
        if (load)
            pre_d = '0;
        else if (count_en)
            pre_d = tick ? '0 : pre_q + 1'b1;  // wraps through all-ones when above prescale

        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick) begin
            if (dir) begin
                if (count_q < modulus)
                    count_d = count_q + 1'b1;
                else
                    count_d = sat_mode ? modulus : '0;
            end else begin
                if (count_q != '0)
                    count_d = count_q - 1'b1;
                else
                    count_d = sat_mode ? '0 : modulus;
            end
        end

        tc_d   = boundary;
        // A boundary event on the same edge as clr_flag keeps the flag set.
        flag_d = boundary ? 1'b1 : (clr_flag ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out = count_q & {WIDTH{oe}};
    assign tc_pulse  = tc_q;
    assign wrap_flag = flag_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Table-driven bench for updown_mod_counter; expected outputs go through a
// scoreboard queue and are compared one cycle after each drive.
module tb_updown_mod_counter;
    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset, load, count_en, dir, sat_mode, clr_flag, oe;
    logic [W-1:0]  load_value, modulus;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count_out;
    logic          tc_pulse, wrap_flag;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .count_en(count_en), .dir(dir), .sat_mode(sat_mode), .modulus(modulus),
        .prescale(prescale), .clr_flag(clr_flag), .oe(oe),
        .count_out(count_out), .tc_pulse(tc_pulse), .wrap_flag(wrap_flag)
    );

    typedef struct {
        logic ld; logic [W-1:0] lv; logic en, dr, sat; logic [W-1:0] md;
        logic [PW-1:0] ps; logic clr, o; logic [W-1:0] ec; logic et, ef;
    } vec_t;
    typedef struct { logic [W-1:0] c; logic t; logic f; string nm; } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv,
                                input logic en, input logic dr, input logic sat,
                                input logic [W-1:0] md, input logic [PW-1:0] ps,
                                input logic clr, input logic o,
                                input logic [W-1:0] ec, input logic et, input logic ef);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.dr = dr; v.sat = sat; v.md = md;
        v.ps = ps; v.clr = clr; v.o = o; v.ec = ec; v.et = et; v.ef = ef;
        return v;
    endfunction

    task automatic cmp1(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = sbq.pop_front();
            cmp1({e.nm, " count_out"}, 32'(count_out), 32'(e.c));
            cmp1({e.nm, " tc_pulse"},  32'(tc_pulse),  32'(e.t));
            cmp1({e.nm, " wrap_flag"}, 32'(wrap_flag), 32'(e.f));
        end
    endtask

    task automatic drive(input vec_t v, input string nm);
        @(negedge clk);
        load = v.ld; load_value = v.lv; count_en = v.en; dir = v.dr;
        sat_mode = v.sat; modulus = v.md; prescale = v.ps; clr_flag = v.clr; oe = v.o;
        sbq.push_back('{v.ec, v.et, v.ef, nm});
        @(posedge clk);
        #1 check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 0; load_value = '0; count_en = 0; dir = 0;
        sat_mode = 0; modulus = '0; prescale = '0; clr_flag = 0; oe = 1;
        repeat (2) @(posedge clk);
        #1;
        sbq.push_back('{8'd0, 1'b0, 1'b0, "reset"});
        check_out();
        @(negedge clk) reset = 1'b0;

        // wrap at modulus 5
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,1,1,0,5,0,0,1, 8'(k),0,0));
        tbl.push_back(mk(0,0,1,1,0,5,0,0,1, 0,1,1));
        tbl.push_back(mk(0,0,1,1,0,5,0,0,1, 1,0,1));
        // saturate at 5, clear loses to a simultaneous boundary event
        tbl.push_back(mk(1,0,1,1,1,5,0,0,1, 0,0,1));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,1,1,1,5,0,0,1, 8'(k),0,1));
        tbl.push_back(mk(0,0,1,1,1,5,0,0,1, 5,1,1));
        tbl.push_back(mk(0,0,1,1,1,5,0,0,1, 5,1,1));
        tbl.push_back(mk(0,0,1,1,1,5,0,1,1, 5,1,1));
        tbl.push_back(mk(0,0,0,1,1,5,0,1,1, 5,0,0));
        // down-count wrap at 9, loads above modulus
        tbl.push_back(mk(1,3,1,0,0,9,0,0,1, 3,0,0));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 2,0,0));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 1,0,0));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 9,1,1));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 8,0,1));
        tbl.push_back(mk(1,12,1,0,0,9,0,0,1, 12,0,1));
        tbl.push_back(mk(0,0,1,0,0,9,0,0,1, 11,0,1));
        tbl.push_back(mk(1,12,1,0,0,9,0,0,1, 12,0,1));
        tbl.push_back(mk(0,0,1,1,0,9,0,0,1, 0,1,1));
        // modulus 0: boundary every tick
        tbl.push_back(mk(1,0,1,1,0,0,0,0,1, 0,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,1, 0,1,1));
        tbl.push_back(mk(0,0,1,1,1,0,0,0,1, 0,1,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,1, 0,1,1));
        // full-range modulus
        tbl.push_back(mk(1,255,1,1,0,255,0,0,1, 255,0,1));
        tbl.push_back(mk(0,0,1,1,0,255,0,0,1, 0,1,1));
        tbl.push_back(mk(0,0,1,0,0,255,0,0,1, 255,1,1));
        tbl.push_back(mk(0,0,1,0,0,255,0,0,1, 254,0,1));
        tbl.push_back(mk(0,0,0,0,0,255,0,1,1, 254,0,0));
        // prescale 3: 4-cycle interval, stretched by 2 disabled cycles, restarted by load
        tbl.push_back(mk(1,0,1,1,0,9,3,0,1, 0,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 0,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,0,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,0,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 1,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 2,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 2,0,0));
        tbl.push_back(mk(1,5,1,1,0,9,3,0,1, 5,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 5,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,3,0,1, 6,0,0));

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("vec%0d", i));

        // prescale lowered below the running pre-count: it runs to all-ones and wraps
        drive(mk(0,0,1,1,0,9,3,0,1, 6,0,0), "ps_lower_a");
        drive(mk(0,0,1,1,0,9,3,0,1, 6,0,0), "ps_lower_b");
        for (int k = 0; k < 15; k++) drive(mk(0,0,1,1,0,9,1,0,1, 6,0,0), $sformatf("ps_wrap%0d", k));
        drive(mk(0,0,1,1,0,9,1,0,1, 7,0,0), "ps_wrap_tick");

        // asynchronous reset between edges while pinned at 7 with tc and flag high
        drive(mk(1,7,1,1,1,7,0,0,1, 7,0,0), "pin_load");
        drive(mk(0,0,1,1,1,7,0,0,1, 7,1,1), "pin_tick");
        #2 reset = 1'b1;
        sbq.push_back('{8'd0, 1'b0, 1'b0, "async_reset"});
        #1 check_out();
        @(posedge clk);
        sbq.push_back('{8'd0, 1'b0, 1'b0, "reset_held"});
        #1 check_out();
        @(negedge clk) begin reset = 1'b0; count_en = 1'b0; end

        // oe gates the output while the count keeps running
        for (int k = 0; k < 3; k++) drive(mk(0,0,1,1,0,9,0,0,0, 0,0,0), $sformatf("oe_off%0d", k));
        drive(mk(0,0,0,1,0,9,0,0,1, 3,0,0), "oe_on");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
